// File: rtl/ram_copy_engine_if.sv
// Control and RAM-port bundle for the copy engine.
// The master side requests copies and models the RAM; the slave side is the engine itself.
interface ram_copy_engine_if #(
    parameter int G = 18
);
    logic          start_i;
    logic [G-1:0]  src_i;
    logic [G-1:0]  dst_i;
    logic [G-1:0]  len_i;
    logic          busy_o;
    logic          done_o;
    logic [G-1:0]  mem_addr_o;
    logic [31:0]   mem_data_o;
    logic          mem_en_o;
    logic          mem_byte_o;
    logic [31:0]   mem_data_i;

    modport master (
        output start_i, src_i, dst_i, len_i, mem_data_i,
        input  busy_o, done_o, mem_addr_o, mem_data_o, mem_en_o, mem_byte_o
    );

    modport slave (
        input  start_i, src_i, dst_i, len_i, mem_data_i,
        output busy_o, done_o, mem_addr_o, mem_data_o, mem_en_o, mem_byte_o
    );
endinterface

// File: rtl/ram_copy_engine.sv
// Copies a byte region through the shared RAM port, using word transfers while at least
// four bytes remain and byte transfers for the tail; strictly ascending, read then write.
module ram_copy_engine #(
    parameter int G = 18
) (
    input  logic               CLK,
    input  logic               RST,
    ram_copy_engine_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_next;
    logic [G-1:0]  src_q;
    logic [G-1:0]  dst_q;
    logic [G-1:0]  rem_q;
    logic [31:0]   buf_q;
    logic          byte_mode;
    logic [G-1:0]  chunk;

    // Byte mode is derived from rem_q, which only changes at the end of WRITE,
    // so READ and WRITE of one chunk always agree.
    assign byte_mode = (rem_q < G'(4));
    assign chunk     = byte_mode ? G'(1) : G'(4);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_next;
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        src_q <= bus.src_i;
                        dst_q <= bus.dst_i;
                        rem_q <= bus.len_i;
                    end
                end
                READ: begin
                    buf_q <= bus.mem_data_i;
                end
                WRITE: begin
                    src_q <= src_q + chunk;
                    dst_q <= dst_q + chunk;
                    rem_q <= rem_q - chunk;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next      = state_q;
        bus.busy_o      = 1'b0;
        bus.done_o      = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_data_o  = '0;
        bus.mem_en_o    = 1'b0;
        bus.mem_byte_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_next = (bus.len_i == '0) ? DONE : READ;
                end
            end
            READ: begin
                bus.busy_o     = 1'b1;
                bus.mem_addr_o = src_q;
                bus.mem_byte_o = byte_mode;
                state_next     = WRITE;
            end
            WRITE: begin
                bus.busy_o     = 1'b1;
                bus.mem_addr_o = dst_q;
                bus.mem_data_o = byte_mode ? {24'b0, buf_q[7:0]} : buf_q;
                bus.mem_en_o   = 1'b1;
                bus.mem_byte_o = byte_mode;
                state_next     = (rem_q == chunk) ? DONE : READ;
            end
            DONE: begin
                bus.done_o = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench for ram_copy_engine with a 1 KiB big-endian RAM model
// (combinational read, falling-edge write).
module tb_ram_copy_engine;
    localparam int G = 10;

    logic CLK;
    logic RST;
    logic clr;
    logic pl_en;
    logic [9:0] pl_addr;
    logic [7:0] pl_data;
    logic [7:0] mem [0:1023];

    int total;
    int bad;

    // Per-copy observations
    int done_cyc, busy_cnt, en_cnt, byte_cnt, upnz_cnt, rd_n;
    logic [9:0] rd_addr [8];

    ram_copy_engine_if #(.G(G)) bus();

    ram_copy_engine #(.G(G)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [9:0] ra0, ra1, ra2, ra3;
    always_comb begin
        ra0 = bus.mem_addr_o;
        ra1 = ra0 + 10'd1;
        ra2 = ra0 + 10'd2;
        ra3 = ra0 + 10'd3;
        if (bus.mem_byte_o)
            bus.mem_data_i = {24'b0, mem[ra0]};
        else
            bus.mem_data_i = {mem[ra0], mem[ra1], mem[ra2], mem[ra3]};
    end

    always @(negedge CLK) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (bus.mem_en_o) begin
            if (bus.mem_byte_o) begin
                mem[ra0] <= bus.mem_data_o[7:0];
            end else begin
                mem[ra0] <= bus.mem_data_o[31:24];
                mem[ra1] <= bus.mem_data_o[23:16];
                mem[ra2] <= bus.mem_data_o[15:8];
                mem[ra3] <= bus.mem_data_o[7:0];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge CLK);
        #1;
        pl_en   = 1'b0;
    endtask

    function automatic logic [31:0] word_at(input logic [9:0] a);
        logic [9:0] a1, a2, a3;
        a1 = a + 10'd1;
        a2 = a + 10'd2;
        a3 = a + 10'd3;
        return {mem[a], mem[a1], mem[a2], mem[a3]};
    endfunction

    // Starts a copy and watches it until done_o or a cycle budget expires.
    // Cycle numbers count from 1 = the cycle after the start edge.
    task automatic run(input logic [9:0] s, input logic [9:0] d, input logic [9:0] l,
                       input bit inject_start);
        @(posedge CLK);
        #1;
        bus.start_i = 1'b1;
        bus.src_i   = s;
        bus.dst_i   = d;
        bus.len_i   = l;
        @(posedge CLK);
        #1;
        bus.start_i = 1'b0;
        done_cyc = 0; busy_cnt = 0; en_cnt = 0; byte_cnt = 0; upnz_cnt = 0; rd_n = 0;
        for (int c = 1; c <= 200; c++) begin
            if (inject_start && c == 1) begin
                bus.start_i = 1'b1;
                bus.src_i   = 10'h000;
                bus.dst_i   = 10'h180;
                bus.len_i   = 10'd8;
            end
            if (inject_start && c == 2) bus.start_i = 1'b0;
            if (bus.busy_o) busy_cnt++;
            if (bus.mem_en_o) en_cnt++;
            if (bus.mem_en_o && bus.mem_byte_o) byte_cnt++;
            if (bus.mem_en_o && bus.mem_byte_o && bus.mem_data_o[31:8] != 24'h0) upnz_cnt++;
            if (bus.busy_o && !bus.mem_en_o && rd_n < 8) begin
                rd_addr[rd_n] = bus.mem_addr_o;
                rd_n++;
            end
            if (bus.done_o) begin
                done_cyc = c;
                break;
            end
            @(posedge CLK);
            #1;
        end
        @(posedge CLK);
        #1;
        chk("done_one_cycle", {31'b0, bus.done_o}, 32'd0);
        $display("copy src=%h dst=%h len=%0d done_cyc=%0d busy=%0d writes=%0d byte_writes=%0d",
                 s, d, l, done_cyc, busy_cnt, en_cnt, byte_cnt);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST = 1'b1;
        clr = 1'b1;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        bus.start_i = 1'b0;
        bus.src_i = '0;
        bus.dst_i = '0;
        bus.len_i = '0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        clr = 1'b0;

        // Reset state
        chk("rst_busy", {31'b0, bus.busy_o}, 32'd0);
        chk("rst_done", {31'b0, bus.done_o}, 32'd0);
        chk("rst_en",   {31'b0, bus.mem_en_o}, 32'd0);
        chk("rst_byte", {31'b0, bus.mem_byte_o}, 32'd0);
        chk("rst_addr", {22'b0, bus.mem_addr_o}, 32'd0);
        chk("rst_data", bus.mem_data_o, 32'd0);

        // Word copy
        poke(10'h000, 8'h11); poke(10'h001, 8'h22); poke(10'h002, 8'h33); poke(10'h003, 8'h44);
        poke(10'h004, 8'h55); poke(10'h005, 8'h66); poke(10'h006, 8'h77); poke(10'h007, 8'h88);
        run(10'h000, 10'h100, 10'd8, 1'b0);
        chk("word_done_cyc", done_cyc, 32'd5);
        chk("word_busy", busy_cnt, 32'd4);
        chk("word_writes", en_cnt, 32'd2);
        chk("word_bytes", byte_cnt, 32'd0);
        chk("word_mem0", word_at(10'h100), 32'h11223344);
        chk("word_mem1", word_at(10'h104), 32'h55667788);

        // Word plus byte tail
        poke(10'h010, 8'hA1); poke(10'h011, 8'hA2); poke(10'h012, 8'hA3);
        poke(10'h013, 8'hA4); poke(10'h014, 8'hA5); poke(10'h015, 8'hA6);
        poke(10'h206, 8'hEE);
        run(10'h010, 10'h200, 10'd6, 1'b0);
        chk("tail_done_cyc", done_cyc, 32'd7);
        chk("tail_writes", en_cnt, 32'd3);
        chk("tail_bytes", byte_cnt, 32'd2);
        chk("tail_upper_zero", upnz_cnt, 32'd0);
        chk("tail_mem0", word_at(10'h200), 32'hA1A2A3A4);
        chk("tail_mem1", word_at(10'h204), 32'hA5A6EE00);

        // Zero length
        poke(10'h300, 8'h5A);
        run(10'h000, 10'h300, 10'd0, 1'b0);
        chk("zero_done_cyc", done_cyc, 32'd1);
        chk("zero_busy", busy_cnt, 32'd0);
        chk("zero_writes", en_cnt, 32'd0);
        chk("zero_mem", {24'b0, mem[10'h300]}, 32'h5A);

        // Overlapping forward copy propagates the first byte
        poke(10'h000, 8'hAB); poke(10'h001, 8'h01); poke(10'h002, 8'h02); poke(10'h003, 8'h03);
        run(10'h000, 10'h001, 10'd3, 1'b0);
        chk("ovl_done_cyc", done_cyc, 32'd7);
        chk("ovl_mem", word_at(10'h000), 32'hABABABAB);

        // Source wraps past the top of the address space
        poke(10'h3FC, 8'hC1); poke(10'h3FD, 8'hC2); poke(10'h3FE, 8'hC3); poke(10'h3FF, 8'hC4);
        poke(10'h000, 8'hD1); poke(10'h001, 8'hD2); poke(10'h002, 8'hD3); poke(10'h003, 8'hD4);
        run(10'h3FC, 10'h000, 10'd8, 1'b0);
        chk("wrap_done_cyc", done_cyc, 32'd5);
        chk("wrap_rd1_addr", {22'b0, rd_addr[1]}, 32'h000);
        chk("wrap_mem0", word_at(10'h000), 32'hC1C2C3C4);
        chk("wrap_mem1", word_at(10'h004), 32'hC1C2C3C4);

        // Reset during the second READ of an 8-byte copy
        @(posedge CLK);
        #1;
        bus.start_i = 1'b1;
        bus.src_i   = 10'h000;
        bus.dst_i   = 10'h380;
        bus.len_i   = 10'd8;
        @(posedge CLK);
        #1;
        bus.start_i = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        chk("abort_in_read", {30'b0, bus.busy_o, bus.mem_en_o}, 32'b10);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("abort_busy", {31'b0, bus.busy_o}, 32'd0);
        chk("abort_addr", {22'b0, bus.mem_addr_o}, 32'd0);
        begin
            int done_seen;
            done_seen = 0;
            for (int c = 0; c < 6; c++) begin
                if (bus.done_o || bus.mem_en_o) done_seen++;
                @(posedge CLK);
                #1;
            end
            chk("abort_no_done", done_seen, 32'd0);
        end
        chk("abort_mem0", word_at(10'h380), 32'hC1C2C3C4);
        chk("abort_mem1", word_at(10'h384), 32'h00000000);
        $display("copy src=000 dst=380 len=8 aborted by reset");

        // start_i pulsed while busy is ignored
        poke(10'h100, 8'h11); poke(10'h101, 8'h22); poke(10'h102, 8'h33); poke(10'h103, 8'h44);
        run(10'h100, 10'h140, 10'd4, 1'b1);
        chk("ign_done_cyc", done_cyc, 32'd3);
        chk("ign_writes", en_cnt, 32'd1);
        chk("ign_mem", word_at(10'h140), 32'h11223344);
        chk("ign_other_dst", word_at(10'h180), 32'h00000000);
        repeat (4) @(posedge CLK);
        #1;
        chk("ign_idle", {31'b0, bus.busy_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_copy_engine.md
# ram_copy_engine

Bus-initiator block that drives the byte-addressable data RAM port (address, data-in, enable, byte-mode, data-out) to copy a contiguous region from a source address to a destination address. It sits beside the processor datapath and takes over the RAM port while busy. It issues word (4-byte, big-endian) accesses while at least 4 bytes remain and byte accesses for the tail. The RAM reads combinationally and writes on the falling edge of CLK; this block runs on the rising edge.

## Interface
- G, 18, RAM address width in bits; all addresses and lengths wrap modulo 2^G.
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- start_i  in  1  request a copy; sampled only in IDLE.
- src_i  in  G  source byte address; captured with start_i.
- dst_i  in  G  destination byte address; captured with start_i.
- len_i  in  G  byte count; captured with start_i; 0 is legal.
- busy_o  out  1  high in READ and WRITE states.
- done_o  out  1  one-cycle pulse when a copy completes.
- mem_addr_o  out  G  RAM address.
- mem_data_o  out  32  RAM write data; byte mode uses bits [7:0], upper 24 bits driven 0.
- mem_en_o  out  1  RAM write enable.
- mem_byte_o  out  1  RAM byte mode (1 = byte, 0 = 32-bit word).
- mem_data_i  in  32  RAM read data; byte mode returns {24'b0, byte}.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: start_i=1 captures src, dst, len into internal registers (src_q, dst_q, rem_q). rem_q=0 -> DONE. Otherwise -> READ.
- READ: mem_addr_o=src_q, mem_en_o=0, mem_byte_o=(rem_q<4). At the rising edge, latch mem_data_i into buf_q and go to WRITE.
- WRITE: mem_addr_o=dst_q, mem_data_o=buf_q (byte mode: {24'b0, buf_q[7:0]}), mem_en_o=1, mem_byte_o held from READ. The RAM commits the write on the falling edge inside this cycle.
- End of the WRITE cycle: src_q and dst_q advance by chunk (4 or 1, modulo 2^G), and rem_q decreases by chunk. rem_q reaching 0 -> DONE. Otherwise -> READ.
- DONE: done_o=1 for one cycle, then IDLE.
- Chunk count N = floor(len/4) + (len mod 4).
- Order is strictly ascending, with each chunk written before the next is read. Overlapping regions therefore follow these sequential semantics: dst inside the source range forward-propagates data. This is the defined behaviour.
- start_i is ignored outside IDLE.
- Output values outside READ/WRITE: mem_en_o=0, mem_byte_o=0, mem_addr_o=0, mem_data_o=0.

## Timing
- Reset values: state=IDLE; busy_o=0; done_o=0; mem_en_o=0; mem_byte_o=0; mem_addr_o=0; mem_data_o=0; internal registers 0.
- start_i sampled high at edge k, len>0:
  - READ occupies cycle k+1.
  - Each chunk takes exactly 2 cycles (READ, WRITE).
  - busy_o is high for 2N cycles.
  - done_o is high in cycle k+2N+1.
  - The block is in IDLE at k+2N+2 and may accept start_i at that edge.
- len=0: done_o high in cycle k+1, busy_o never rises, mem_en_o never rises.
- mem_en_o is high only in WRITE cycles, exactly N times per copy.
- Address wrap: src_q or dst_q at 2^G-4 with a word chunk wraps to 0. The RAM itself wraps the intra-word bytes.
- RST high at any edge, including mid-copy, overrides everything:
  - Next cycle is IDLE with all outputs at reset values.
  - The write in the WRITE cycle where RST is sampled still completes at the falling edge, because it precedes the reset edge.
  - No done_o pulse is produced for an aborted copy.
- start_i held high continuously: a new copy starts on the first IDLE cycle after DONE.

## Test plan
- Word copy: preload 0x000..0x007 = 11,22,33,44,55,66,77,88; start src=0x000, dst=0x100, len=8 -> 2 word writes (mem_byte_o=0), mem[0x100..0x107] match; done_o at cycle k+5.
- Tail bytes: len=6, src=0x010 -> 1 word + 2 byte writes; N=3; done_o at k+7; mem_byte_o=1 on last two WRITEs; mem_data_o[31:8]=0 during byte writes.
- Zero length: len=0 -> done_o at k+1, busy_o stays 0, no mem_en_o pulse, RAM unchanged.
- Overlap forward: mem[0]=0xAB, src=0, dst=1, len=3 -> bytes 1..3 all 0xAB.
- Wrap: G=10, src=0x3FC, dst=0x000, len=8 -> second read at address 0x000 after the wrap; dst receives the bytes from 0x3FC..0x3FF followed by the bytes from 0x000..0x003, with the second word read after the first write, per sequential semantics.
- Reset and ignored start:
  - RST asserted during the second READ of a len=8 copy -> next cycle IDLE, outputs 0, no done_o, first word already written.
  - start_i pulsed while busy -> ignored; copy completes with the original parameters.
